multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports, one clock domain, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- Opcode  in  6  instruction bits 31:26, taken from the instruction register
- PCWriteCond  out  1  PC write enable, qualified by the branch compare
- PCWrite  out  1  unconditional PC write enable
- IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
- MemRead, MemWrite  out  1 each  memory strobes
- MemtoReg  out  1  register write-data select (1 = memory data register)
- IRWrite  out  1  instruction register load
- ALUSrcA  out  1  ALU A select (0 = PC, 1 = A register)
- RegWrite  out  1  register file write
- RegDst  out  1  destination register select (1 = rd, 0 = rt)
- ALUSrcB  out  2  ALU B select (00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2)
- PCSource  out  2  next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target)
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- IllegalOp  out  1  one-cycle flag: unsupported opcode
- State  out  4  current state code, for debug

Function
REQ-002 The block SHALL be a Moore FSM: every output is a function of the current state only, except IllegalOp.
REQ-003 The block SHALL decode these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-004 The states and their encodings SHALL be:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11
REQ-005 Transitions:
- FETCH->DECODE
- DECODE->MEMADR on lw/sw, EXEC on R-type, BRANCH on beq, JUMP on j, ADDIEX on addi, FETCH otherwise
- MEMADR->MEMRD on lw, MEMWR on sw
- MEMRD->MEMWB
- EXEC->RWB
- ADDIEX->ADDIWB
- MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB->FETCH
REQ-006 Outputs asserted per state; every output not listed for a state SHALL be 0:
- FETCH: MemRead, IRWrite, PCWrite=1; ALUSrcB=01
- DECODE: ALUSrcB=11
- MEMADR: ALUSrcA=1, ALUSrcB=10
- MEMRD: MemRead, IorD=1
- MEMWB: RegWrite, MemtoReg=1
- MEMWR: MemWrite, IorD=1
- EXEC: ALUSrcA=1, ALUOp=10
- RWB: RegWrite, RegDst=1
- BRANCH: ALUSrcA, PCWriteCond=1; ALUOp=01, PCSource=01
- JUMP: PCWrite=1, PCSource=10
- ADDIEX: ALUSrcA=1, ALUSrcB=10
- ADDIWB: RegWrite=1
REQ-007 IllegalOp SHALL be 1 only in DECODE with an undecoded Opcode; the following state SHALL be FETCH.
REQ-008 Opcode SHALL be sampled only in DECODE and MEMADR; its value in any other state SHALL be ignored.
REQ-009 Instruction latency in cycles, FETCH to the return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-010 An unreachable state encoding (12-15) SHALL go to FETCH on the next edge, with all outputs 0.
REQ-011 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-012 RegWrite and PCWrite SHALL never be 1 in the same cycle.

Reset
REQ-013 While reset=0 the state SHALL be FETCH, applied asynchronously, without waiting for clk.
REQ-014 Reset asserted in any state, mid-instruction, SHALL abandon that instruction; no further write strobe from it SHALL appear.
REQ-015 The first rising clk edge after reset deasserts SHALL move FETCH->DECODE.
REQ-016 While in reset the outputs SHALL be the FETCH outputs.

Structure
REQ-017 The opcode constants, state encodings, and ALUOp/ALUSrcB/PCSource codes SHALL live in a shared package used by the datapath top.
REQ-018 The block SHALL be built from two parts:
- a state register with next-state logic
- one sub-module, control_decode, a combinational state-to-output map

Verification
REQ-019 Reset=0 mid-MEMRD, then released -> state 0 immediately; the next cycle is state 1 with MemWrite/RegWrite never seen.
REQ-020 Opcode=100011 -> states 0,1,2,3,4; MemtoReg=1 and RegWrite=1 only in state 4.
REQ-021 Opcode=101011 -> states 0,1,2,5,0; MemWrite=1 with IorD=1 in state 5 only.
REQ-022 Opcode=000100 -> states 0,1,8,0; PCWriteCond=1, ALUOp=01, PCSource=01 in state 8.
REQ-023 Opcode=000010, then 001000 -> states 0,1,9,0,1,10,11,0; PCSource=10 in state 9, RegWrite=1 with RegDst=0 in state 11.
REQ-024 Opcode=111111 -> IllegalOp=1 for exactly one cycle in state 1, then state 0; an assertion checks REQ-011/012 over all runs.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - opcodes, state encodings and control field codes
package multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B        = 2'b00;
   localparam logic [1:0] SRCB_FOUR     = 2'b01;
   localparam logic [1:0] SRCB_IMM      = 2'b10;
   localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational state-to-control map of the multicycle FSM
import multicycle_control_pkg::*;

module control_decode (
   input  state_t     state,
   output logic       PCWriteCond,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp
);

   always_comb begin
      PCWriteCond = 1'b0;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcB     = SRCB_B;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = SRCB_FOUR;
         end
         S_DECODE: ALUSrcB = SRCB_IMM_SHL2;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            PCWriteCond = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDIWB: RegWrite = 1'b1;
         // Unreachable encodings keep every strobe low.
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing a multicycle MIPS-subset datapath
import multicycle_control_pkg::*;

module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   output logic       PCWriteCond,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic       IllegalOp,
   output logic [3:0] State
);

   state_t state, state_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_next;
   end

   // Opcode is only consulted in DECODE and MEMADR; elsewhere it is don't-care.
   always_comb begin
      state_next = S_FETCH;
      IllegalOp  = 1'b0;
      case (state)
         S_FETCH: state_next = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXEC;
               OP_BEQ:       state_next = S_BRANCH;
               OP_J:         state_next = S_JUMP;
               OP_ADDI:      state_next = S_ADDIEX;
               default: begin
                  IllegalOp  = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEMADR: state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_next = S_MEMWB;
         S_EXEC:   state_next = S_RWB;
         S_ADDIEX: state_next = S_ADDIWB;
         default:  state_next = S_FETCH;
      endcase
   end

   assign State = state;

   control_decode u_decode (
      .state       (state),
      .PCWriteCond (PCWriteCond),
      .PCWrite     (PCWrite),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .IRWrite     (IRWrite),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed and random instruction runs against a sequence model
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode;
   logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic       ALUSrcA, RegWrite, RegDst, IllegalOp;
   logic [1:0] ALUSrcB, PCSource, ALUOp;
   logic [3:0] State;

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic pcwc, pcw, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
      logic [1:0] srcb, pcsrc, aluop;
   } ctl_t;

   multicycle_control dut (
      .clk(clk), .reset(reset), .Opcode(Opcode),
      .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
   );

   always #5 clk = ~clk;

   function automatic logic legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   // State walk of one instruction, from FETCH up to (not including) the return to FETCH.
   function automatic void instr_seq(input logic [5:0] op, output int seq[$]);
      seq = {0, 1};
      case (op)
         6'b100011: seq = {seq, 2, 3, 4};
         6'b101011: seq = {seq, 2, 5};
         6'b000000: seq = {seq, 6, 7};
         6'b001000: seq = {seq, 10, 11};
         6'b000100: seq.push_back(8);
         6'b000010: seq.push_back(9);
         default: ;
      endcase
   endfunction

   function automatic ctl_t exp_ctl(input int s);
      ctl_t c = '0;
      case (s)
         0:  begin c.mrd = 1; c.irw = 1; c.pcw = 1; c.srcb = 2'b01; end
         1:  c.srcb = 2'b11;
         2:  begin c.srca = 1; c.srcb = 2'b10; end
         3:  begin c.mrd = 1; c.iord = 1; end
         4:  begin c.rw = 1; c.m2r = 1; end
         5:  begin c.mwr = 1; c.iord = 1; end
         6:  begin c.srca = 1; c.aluop = 2'b10; end
         7:  begin c.rw = 1; c.rdst = 1; end
         8:  begin c.srca = 1; c.pcwc = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; end
         9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
         10: begin c.srca = 1; c.srcb = 2'b10; end
         11: c.rw = 1;
         default: ;
      endcase
      return c;
   endfunction

   function automatic ctl_t obs_ctl();
      return {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
              ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource, ALUOp};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_cycle(input int s, input logic ill);
      check("state", 32'(State), 32'(s));
      check("ctl", 32'(obs_ctl()), 32'(exp_ctl(s)));
      check("illegal", 32'(IllegalOp), 32'(ill));
      check("mem_mutex", 32'(MemRead & MemWrite), 32'd0);
      check("wr_mutex", 32'(RegWrite & PCWrite), 32'd0);
   endtask

   // Called just after a rising edge; runs seq[start..] checking each cycle on the falling edge.
   task automatic run_instr(input logic [5:0] op, input int start);
      int seq[$];
      instr_seq(op, seq);
      for (int i = start; i < seq.size(); i++) begin
         Opcode = (seq[i] == 1 || seq[i] == 2) ? op : 6'($urandom);
         @(negedge clk);
         check_cycle(seq[i], seq[i] == 1 && !legal(op));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [5:0] op;
      int r;
      reset  = 1'b0;
      Opcode = 6'b100011;
      #2;
      check_cycle(0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("first_edge", 32'(State), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("resync_fetch", 32'(State), 32'd0);

      run_instr(6'b100011, 0);
      run_instr(6'b101011, 0);
      run_instr(6'b000100, 0);
      run_instr(6'b000010, 0);
      run_instr(6'b001000, 0);
      run_instr(6'b000000, 0);
      run_instr(6'b111111, 0);
      check("after_illegal", 32'(State), 32'd0);

      // Reset mid-MEMRD abandons the load.
      run_instr(6'b100011, 0);
      Opcode = 6'b100011;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("in_memrd", 32'(State), 32'd3);
      #1 reset = 1'b0;
      #1 check_cycle(0, 1'b0);
      @(posedge clk); #1;
      check_cycle(0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      run_instr(6'b000100, 1);
      check("post_reset_fetch", 32'(State), 32'd0);

      for (int n = 0; n < 60; n++) begin
         r = int'($urandom_range(0, 6));
         case (r)
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = 6'b001000;
            default: begin
               op = 6'($urandom);
               while (legal(op)) op = 6'($urandom);
            end
         endcase
         run_instr(op, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
